// File: rtl/pfsched.sv
// Two-source prefetch scheduler: per-source FIFOs with line-level duplicate
// filtering, a round-robin issue slot and an outstanding-prefetch credit limit.
module pfsched #(
  parameter int PA_W      = 50,
  parameter int LINE_BITS = 6,
  parameter int DEPTH     = 4,
  parameter int MAX_OUT   = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [PA_W-1:0] l1req_paddr,
  input  logic            l1req_valid,
  output logic            l1req_retry,
  input  logic [PA_W-1:0] l2req_paddr,
  input  logic            l2req_valid,
  output logic            l2req_retry,
  output logic [PA_W-1:0] pfreq_paddr,
  output logic            pfreq_src,
  output logic            pfreq_valid,
  input  logic            pfreq_retry,
  input  logic            pfdone_valid,
  output logic            busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = PA_W - LINE_BITS;

  logic [PA_W-1:0] reqPaddr [2];
  logic [1:0]      reqValid;

  logic [PA_W-1:0] mem_q      [2][DEPTH];
  logic [AW:0]     wrPtr_q    [2];
  logic [AW:0]     rdPtr_q    [2];
  logic [LW-1:0]   lastLine_q [2];
  logic [1:0]      lastVld_q;
  logic            slotVld_q;
  logic            slotSrc_q;
  logic            rrLast_q;
  logic [PA_W-1:0] slotAddr_q;
  logic [3:0]      outCnt_q;
  logic [3:0]      outCnt_d;

  logic [1:0]      empty, full, accept, push, cand, pop, wrEn;
  logic [PA_W-1:0] head [2];
  logic            slotFree, load, grant, doneDec;

  assign reqPaddr[0] = l1req_paddr;
  assign reqPaddr[1] = l2req_paddr;
  assign reqValid    = {l2req_valid, l1req_valid};

  // An empty FIFO presents the incoming request as its head, so a fresh
  // request can be loaded into the slot on the same edge it is accepted.
  always_comb begin
    empty  = '0;
    full   = '0;
    accept = '0;
    push   = '0;
    cand   = '0;
    for (int s = 0; s < 2; s++) begin
      empty[s]  = (wrPtr_q[s] == rdPtr_q[s]);
      full[s]   = (wrPtr_q[s][AW] != rdPtr_q[s][AW]) &&
                  (wrPtr_q[s][AW-1:0] == rdPtr_q[s][AW-1:0]);
      accept[s] = reqValid[s] && !full[s];
      push[s]   = accept[s] &&
                  !(lastVld_q[s] && (reqPaddr[s][PA_W-1:LINE_BITS] == lastLine_q[s]));
      cand[s]   = !empty[s] || push[s];
      head[s]   = empty[s] ? reqPaddr[s] : mem_q[s][rdPtr_q[s][AW-1:0]];
    end
  end

  always_comb begin
    slotFree = !slotVld_q || !pfreq_retry;
    load     = slotFree && enable && (outCnt_q < 4'(MAX_OUT)) && (|cand);
    grant    = (&cand) ? ~rrLast_q : ~cand[0];
    doneDec  = pfdone_valid && (outCnt_q != 4'd0);
    pop      = '0;
    wrEn     = '0;
    for (int s = 0; s < 2; s++) begin
      pop[s]  = load && (grant == 1'(s)) && !empty[s];
      wrEn[s] = push[s] && !(load && (grant == 1'(s)) && empty[s]);
    end
    case ({load, doneDec})
      2'b10:   outCnt_d = outCnt_q + 4'd1;
      2'b01:   outCnt_d = outCnt_q - 4'd1;
      default: outCnt_d = outCnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++)
      if (wrEn[s]) mem_q[s][wrPtr_q[s][AW-1:0]] <= reqPaddr[s];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < 2; s++) begin
        wrPtr_q[s]    <= '0;
        rdPtr_q[s]    <= '0;
        lastLine_q[s] <= '0;
      end
      lastVld_q  <= '0;
      slotVld_q  <= 1'b0;
      slotSrc_q  <= 1'b0;
      slotAddr_q <= '0;
      rrLast_q   <= 1'b1;
      outCnt_q   <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (wrEn[s]) wrPtr_q[s] <= wrPtr_q[s] + {{AW{1'b0}}, 1'b1};
        if (pop[s])  rdPtr_q[s] <= rdPtr_q[s] + {{AW{1'b0}}, 1'b1};
        if (accept[s]) begin
          lastLine_q[s] <= reqPaddr[s][PA_W-1:LINE_BITS];
          lastVld_q[s]  <= 1'b1;
        end
      end
      if (load) begin
        slotVld_q  <= 1'b1;
        slotAddr_q <= head[grant];
        slotSrc_q  <= grant;
        rrLast_q   <= grant;
      end else if (slotFree) begin
        slotVld_q  <= 1'b0;
      end
      outCnt_q <= outCnt_d;
    end
  end

  assign l1req_retry = full[0];
  assign l2req_retry = full[1];
  assign pfreq_paddr = slotAddr_q;
  assign pfreq_src   = slotSrc_q;
  assign pfreq_valid = slotVld_q;
  assign busy        = !(&empty) || slotVld_q || (outCnt_q != 4'd0);

endmodule

// File: doc/pfsched.md
PFSCHED -- requirements
Module: pfsched

Interface
REQ-001 Parameter PA_W, default 50: physical address width.
REQ-002 Parameter LINE_BITS, default 6: line offset bits ignored by duplicate filter.
REQ-003 Parameter DEPTH, default 4: per-source queue depth; power of 2, at least 2.
REQ-004 Parameter MAX_OUT, default 8: maximum outstanding prefetches, 1 to 15.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 enable  in  1  1 = scheduler may issue; 0 = hold queues.
REQ-008 l1req_paddr  in  PA_W  prefetch address from L1 monitor.
REQ-009 l1req_valid  in  1  L1 request present.
REQ-010 l1req_retry  out  1  L1 request not accepted this cycle.
REQ-011 l2req_paddr, l2req_valid, l2req_retry: same as REQ-008..010 for the L2 monitor.
REQ-012 pfreq_paddr  out  PA_W  issued prefetch address.
REQ-013 pfreq_src  out  1  0 = L1 source, 1 = L2 source.
REQ-014 pfreq_valid  out  1  issue slot occupied.
REQ-015 pfreq_retry  in  1  downstream not accepting.
REQ-016 pfdone_valid  in  1  one outstanding prefetch completed.
REQ-017 busy  out  1  any queue, the issue slot, or the outstanding count non-zero.

Function
REQ-018 A handshake on any port occurs when valid=1 and retry=0 in the same cycle.
REQ-019 Each source has a FIFO of DEPTH entries; reqX_retry = 1 exactly when its FIFO is full; this is combinational from FIFO state only.
REQ-020 Duplicate filter: an accepted request whose paddr[PA_W-1:LINE_BITS] equals that source's last accepted line is dropped, with retry=0 and no FIFO write; the last-line register is invalid after reset.
REQ-021 Issue slot loads when (pfreq_valid=0 or pfreq_retry=0), enable=1, outstanding<MAX_OUT, and at least one FIFO is non-empty.
REQ-022 Arbitration: if both FIFOs are non-empty, grant the source not granted last; if only one is non-empty, grant that source; the round-robin pointer updates only on a load; the pointer resets to favour L1.
REQ-023 The slot holds pfreq_paddr/pfreq_src stable while pfreq_valid=1 and pfreq_retry=1.
REQ-024 Latency: a request accepted into an empty FIFO at cycle N, with slot free and credit available, drives pfreq_valid=1 at cycle N+1; there is no combinational input-to-pfreq path.
REQ-025 Outstanding counter (4 bits): +1 on slot load, -1 on pfdone_valid; simultaneous load and done leaves the count unchanged; done at count 0 is ignored with no underflow.
REQ-026 enable=0: no new loads; an occupied slot still completes its handshake; FIFOs still accept requests.
REQ-027 A FIFO enqueue and dequeue in the same cycle on a full FIFO is not allowed; retry stays 1 that cycle.
REQ-028 Pointer wrap: FIFO read/write pointers wrap modulo DEPTH using an extra MSB for full/empty.

Reset
REQ-029 Reset assertion immediately clears FIFOs, last-line registers, the slot, the outstanding count and the RR pointer, even mid-operation; queued requests are discarded.
REQ-030 Reset values: pfreq_valid=0, pfreq_paddr=0, pfreq_src=0, l1req_retry=0, l2req_retry=0, busy=0.
REQ-031 Deassertion is synchronised externally; the first operation occurs on the first rising edge after release.

Verification
REQ-032 Single L1 request 0x1000 at cycle 5, retry=0 -> pfreq_valid=1, pfreq_paddr=0x1000, pfreq_src=0 at cycle 6; count=1.
REQ-033 L1 0x1000 then 0x1020 (same line) -> second accepted, not issued; only one pfreq.
REQ-034 Both sources fill 4 entries each, pfreq_retry=0 -> issue order L1,L2,L1,L2,...; 5th request per source sees retry=1 until a dequeue.
REQ-035 MAX_OUT=8, no pfdone -> exactly 8 issues, then pfreq_valid=0; one pfdone -> exactly one more issue.
REQ-036 pfreq_retry=1 for 10 cycles -> paddr/src stable; enable=0 mid-stream -> slot drains, no new loads, busy=1.
REQ-037 reset asserted with 3 queued and the slot full -> next cycle all outputs at reset values and busy=0.
